// File: rtl/agu_pkg.sv
// Shared types and helpers for the N-dimensional address generation unit.
// Holds the controller state encoding, default sizing and slice extraction for flattened vectors.
package agu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } agu_state_e;

    localparam int unsigned AGU_BWADDR   = 21;
    localparam int unsigned AGU_BWLENGTH = 8;
    localparam int unsigned AGU_NDIM     = 5;

    localparam int unsigned SLICE_MAX_W = 32;
    localparam int unsigned VEC_MAX_W   = 512;

    // Returns slice k (each w bits wide) of a flattened vector, right-aligned;
    // the caller narrows the result to its own field width.
    function automatic logic [SLICE_MAX_W-1:0] agu_slice(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          k,
        input int unsigned          w
    );
        logic [VEC_MAX_W-1:0] shifted;
        shifted = vec >> (k * w);
        return shifted[SLICE_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/agu_dimsel.sv
// Trailing-zero-run encoder: counts how many consecutive counters, starting at i_0,
// are already zero. That count selects the dimension that steps on the next beat.
module agu_dimsel
    import agu_pkg::*;
#(
    parameter int NDIM = AGU_NDIM,
    parameter int KW   = $clog2(NDIM)
) (
    input  logic [NDIM-2:0] zero_i,
    output logic [KW-1:0]   k_o
);

    logic run;

    always_comb begin
        k_o = '0;
        run = 1'b1;
        for (int i = 0; i < NDIM - 1; i++) begin
            if (run && zero_i[i]) begin
                k_o = KW'(i + 1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/agu_nd.sv
// N-dimensional nested-loop address generator with ready/valid output and optional
// endless repeat; inner dimension 0 steps fastest, each dimension adds its own jump.
module agu_nd
    import agu_pkg::*;
#(
    parameter int BWADDR   = AGU_BWADDR,
    parameter int BWLENGTH = AGU_BWLENGTH,
    parameter int NDIM     = AGU_NDIM
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         repeat_en,
    input  logic                         abort,
    input  logic [BWADDR-1:0]            base,
    input  logic [(NDIM-1)*BWLENGTH-1:0] l,
    input  logic [NDIM*BWADDR-1:0]       j,
    output logic [BWADDR-1:0]            addr,
    output logic                         addr_valid,
    input  logic                         addr_ready,
    output logic                         addr_last,
    output logic [NDIM-2:0]              z,
    output logic                         busy,
    output logic                         done
);

    localparam int NCNT = NDIM - 1;
    localparam int KW   = $clog2(NDIM);

    logic [BWLENGTH-1:0] l_in [NCNT];
    logic [BWADDR-1:0]   j_in [NDIM];

    for (genvar g = 0; g < NCNT; g++) begin : g_lslice
        assign l_in[g] = BWLENGTH'(agu_slice(VEC_MAX_W'(l), g, BWLENGTH));
    end
    for (genvar g = 0; g < NDIM; g++) begin : g_jslice
        assign j_in[g] = BWADDR'(agu_slice(VEC_MAX_W'(j), g, BWADDR));
    end

    agu_state_e          state_q, state_d;
    logic [BWADDR-1:0]   addr_q, addr_d;
    logic [BWLENGTH-1:0] cnt_q [NCNT];
    logic [BWLENGTH-1:0] cnt_d [NCNT];
    logic [BWLENGTH-1:0] l_q [NCNT];
    logic [BWLENGTH-1:0] l_d [NCNT];
    logic [BWADDR-1:0]   j_q [NDIM];
    logic [BWADDR-1:0]   j_d [NDIM];
    logic                rep_q, rep_d;
    logic                done_q, done_d;

    logic [NCNT-1:0]     zf;
    logic [KW-1:0]       ksel;
    logic                last;

    for (genvar g = 0; g < NCNT; g++) begin : g_zf
        assign zf[g] = (cnt_q[g] == '0);
    end
    assign last = &zf;

    agu_dimsel #(
        .NDIM (NDIM),
        .KW   (KW)
    ) u_dimsel (
        .zero_i (zf),
        .k_o    (ksel)
    );

    // When all counters are zero ksel == NDIM-1, so the same update reloads every
    // counter and applies the outermost jump: exactly the repeat restart.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        l_d     = l_q;
        j_d     = j_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_RUN;
                    l_d     = l_in;
                    j_d     = j_in;
                    rep_d   = repeat_en;
                    cnt_d   = l_in;
                    addr_d  = base;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (addr_ready) begin
                    addr_d = addr_q + j_q[ksel];
                    for (int m = 0; m < NCNT; m++) begin
                        if (KW'(m) < ksel) begin
                            cnt_d[m] = l_q[m];
                        end else if (KW'(m) == ksel) begin
                            cnt_d[m] = cnt_q[m] - BWLENGTH'(1);
                        end
                    end
                    if (last && !rep_q) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rep_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int m = 0; m < NCNT; m++) begin
                cnt_q[m] <= '0;
                l_q[m]   <= '0;
            end
            for (int m = 0; m < NDIM; m++) begin
                j_q[m] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rep_q   <= rep_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            l_q     <= l_d;
            j_q     <= j_d;
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign addr_valid = busy;
    assign addr       = addr_q;
    assign addr_last  = busy & last;
    assign z          = busy ? zf : '0;
    assign done       = done_q;

endmodule

// File: tb/tb_agu_nd.sv
// Directed bench for agu_nd: a 3-D instance for sequencing/backpressure/repeat/reset,
// and an 8-bit-address 2-D instance for modular wrap.
module tb_agu_nd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start, repeat_en, abort, ready;
    logic [20:0] base;
    logic [15:0] l;
    logic [62:0] j;
    logic [20:0] addr;
    logic        valid, last, busy, done;
    logic [1:0]  z;

    logic        startb, readyb, repb, abortb;
    logic [7:0]  baseb, lb;
    logic [15:0] jb;
    logic [7:0]  addrb;
    logic        validb, lastb, busyb, doneb;
    logic [0:0]  zb;

    always #5 clk = ~clk;

    agu_nd #(.BWADDR(21), .BWLENGTH(8), .NDIM(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .repeat_en(repeat_en), .abort(abort),
        .base(base), .l(l), .j(j), .addr(addr), .addr_valid(valid), .addr_ready(ready),
        .addr_last(last), .z(z), .busy(busy), .done(done)
    );

    agu_nd #(.BWADDR(8), .BWLENGTH(8), .NDIM(2)) dutb (
        .clk(clk), .rst_n(rst_n), .start(startb), .repeat_en(repb), .abort(abortb),
        .base(baseb), .l(lb), .j(jb), .addr(addrb), .addr_valid(validb), .addr_ready(readyb),
        .addr_last(lastb), .z(zb), .busy(busyb), .done(doneb)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    int         exp_a    [16];
    logic       exp_last [16];
    logic [1:0] exp_z    [16];

    task automatic set_pass(input int off, input int b);
        int         d  [6];
        logic [1:0] zz [6];
        d  = '{0, 1, 2, 12, 13, 14};
        zz = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 6; i++) begin
            exp_a[off+i]    = b + d[i];
            exp_last[off+i] = (i == 5);
            exp_z[off+i]    = zz[i];
        end
    endtask

    task automatic launch(input int b, input int l0, input int l1, input int j0,
                          input int j1, input int j2, input logic rep);
        base      = 21'(b);
        l         = {8'(l1), 8'(l0)};
        j         = {21'(j2), 21'(j1), 21'(j0)};
        repeat_en = rep;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base      = '0;
        l         = '0;
        j         = '0;
        repeat_en = 1'b0;
    endtask

    task automatic collect(input int n, input bit toggle);
        int          idx;
        int          cyc;
        logic        stall;
        logic [20:0] pa;
        logic [1:0]  pz;
        logic        pl;
        idx = 0; cyc = 0; stall = 1'b0; pa = '0; pz = '0; pl = 1'b0;
        while (idx < n && cyc < 100) begin
            ready = toggle ? (cyc % 3 == 0) : 1'b1;
            if (stall) begin
                chk("hold_addr", 32'(addr), 32'(pa));
                chk("hold_z", 32'(z), 32'(pz));
                chk("hold_last", 32'(last), 32'(pl));
            end
            chk("valid_run", 32'(valid), 1);
            chk("done_run", 32'(done), 0);
            if (ready) begin
                chk($sformatf("addr[%0d]", idx), 32'(addr), exp_a[idx]);
                chk($sformatf("last[%0d]", idx), 32'(last), 32'(exp_last[idx]));
                chk($sformatf("z[%0d]", idx), 32'(z), 32'(exp_z[idx]));
                idx++;
                stall = 1'b0;
            end else begin
                stall = 1'b1;
                pa = addr; pz = z; pl = last;
            end
            cyc++;
            @(negedge clk);
        end
        ready = 1'b1;
        if (idx < n) chk("collect_timeout", idx, n);
    endtask

    task automatic expect_done;
        chk("done_pulse", 32'(done), 1);
        chk("idle_after", 32'(busy), 0);
        chk("valid_after", 32'(valid), 0);
        @(negedge clk);
        chk("done_once", 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wa [4];
        int wb [4];
        start = 0; repeat_en = 0; abort = 0; ready = 1; base = '0; l = '0; j = '0;
        startb = 0; readyb = 1; repb = 0; abortb = 0; baseb = '0; lb = '0; jb = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_z", 32'(z), 0);
        chk("rst_validb", 32'(validb), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic 3x2 walk, ready always high
        set_pass(0, 100);
        launch(100, 2, 1, 1, 10, 0, 1'b0);
        collect(6, 1'b0);
        expect_done();

        // same walk under backpressure
        launch(100, 2, 1, 1, 10, 0, 1'b0);
        collect(6, 1'b1);
        expect_done();

        // repeat mode: second pass offset by j2, ends only on abort
        set_pass(0, 100);
        set_pass(6, 164);
        launch(100, 2, 1, 1, 10, 50, 1'b1);
        collect(12, 1'b0);
        chk("rep_busy", 32'(busy), 1);
        chk("rep_nodone", 32'(done), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", 32'(done), 1);
        chk("abort_valid", 32'(valid), 0);
        @(negedge clk);
        chk("abort_done_once", 32'(done), 0);

        // reset in the middle of a sequence
        set_pass(0, 100);
        launch(100, 2, 1, 1, 10, 0, 1'b0);
        collect(2, 1'b0);
        chk("pre_rst_addr", 32'(addr), 102);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_addr", 32'(addr), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_nodone", 32'(done), 0);
            chk("post_rst_idle", 32'(busy), 0);
            @(negedge clk);
        end
        set_pass(0, 500);
        launch(500, 2, 1, 1, 10, 0, 1'b0);
        collect(6, 1'b0);
        expect_done();

        // single-beat sequence, start ignored in RUN, abort beats start in IDLE
        launch(7, 0, 0, 1, 1, 1, 1'b0);
        ready = 1'b0;
        start = 1'b1;
        base  = 21'd999;
        @(negedge clk);
        start = 1'b0;
        chk("run_start_addr", 32'(addr), 7);
        chk("run_start_busy", 32'(busy), 1);
        exp_a[0] = 7; exp_last[0] = 1'b1; exp_z[0] = 2'b11;
        collect(1, 1'b0);
        expect_done();
        abort = 1'b1;
        start = 1'b1;
        base  = 21'd55;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_busy", 32'(busy), 0);
        chk("abort_start_valid", 32'(valid), 0);
        @(negedge clk);
        chk("abort_start_busy2", 32'(busy), 0);
        chk("abort_start_done", 32'(done), 0);

        // 8-bit address wrap, positive and negative strides
        wa = '{250, 253, 0, 3};
        wb = '{250, 249, 248, 247};
        for (int t = 0; t < 2; t++) begin
            baseb  = 8'd250;
            lb     = 8'd3;
            jb     = {8'd0, (t == 0) ? 8'd3 : 8'd255};
            startb = 1'b1;
            @(negedge clk);
            startb = 1'b0;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("wrap%0d_addr[%0d]", t, i), 32'(addrb), (t == 0) ? wa[i] : wb[i]);
                chk($sformatf("wrap%0d_last[%0d]", t, i), 32'(lastb), (i == 3) ? 1 : 0);
                chk($sformatf("wrap%0d_z[%0d]", t, i), 32'(zb), (i == 3) ? 1 : 0);
                @(negedge clk);
            end
            chk($sformatf("wrap%0d_done", t), 32'(doneb), 1);
            chk($sformatf("wrap%0d_idle", t), 32'(validb), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
